uart_report_framer: RTL and testbench
=====================================

# uart_report_framer

Frame controller between the dB power converter and the UART transmitter in the receiver signal chain. Each accepted power report is serialised into a byte frame (sync, sequence number, report bytes MSB first, optional checksum). Bytes are pushed into the UART transmit FIFO one per cycle, honouring FIFO-full backpressure. Reports arriving while a frame is in flight are dropped and counted, so the UART link never carries torn frames.

## Interface
Parameters:
- DW, 16, report width in bits; multiple of 8, range 8..32; NBYTES = DW/8
- SYNC_BYTE, 8'hA5, first byte of every frame

Ports:
- clk  input  1  system clock; the only clock
- rst  input  1  synchronous, active-high reset
- data_i  input  DW  power report (converter dB output)
- valid_i  input  1  one-cycle strobe qualifying data_i
- uart_fifo_full_i  input  1  UART transmit FIFO full
- uart_data_o  output  8  byte to UART FIFO
- uart_wr_en_o  output  1  write strobe to UART FIFO
- busy_o  output  1  frame in flight (state != IDLE)
- frame_done_o  output  1  one-cycle pulse on the write of the last frame byte
- seq_o  output  8  sequence number of the next frame
- drop_count_o  output  8  saturating count of dropped reports

## Operation
- States: IDLE, SYNC, SEQ, DATA, CSUM. CSUM exists only with REPORT_CHECKSUM_EN.
- IDLE: on valid_i, latch data_i into the shift register, clear the checksum accumulator, and go to SYNC. Otherwise stay.
- Emitting states (SYNC, SEQ, DATA, CSUM) write one byte per cycle when uart_fifo_full_i=0:
  - SYNC: writes SYNC_BYTE, then goes to SEQ.
  - SEQ: writes seq_o, then goes to DATA with byte index 0.
  - DATA: writes data byte [DW-1-8i -: 8]. It advances the index, and after index NBYTES-1 goes to CSUM, or to IDLE without the macro.
  - CSUM: writes the accumulator, then goes to IDLE.
- Write strobe: uart_wr_en_o = emitting state AND NOT uart_fifo_full_i. This is combinational from registered state and the same-cycle full flag.
- While full: uart_wr_en_o=0, state and uart_data_o are held, and nothing is skipped.
- uart_data_o is driven from registered state and index; it is 8'h00 in IDLE.
- Checksum: XOR of the SEQ byte and all data bytes, accumulated on each successful write. SYNC is excluded.
- Sequence: seq_o increments (mod 256, 255 wraps to 0) on the write of the last frame byte, the same cycle as frame_done_o.
- Drops:
  - valid_i is accepted only when state=IDLE at the clock edge.
  - valid_i in any other state, including the last-byte cycle, is discarded and increments drop_count_o.
  - drop_count_o saturates at 8'hFF.
  - A dropped report never alters the frame in flight.

## Timing
- Reset values: uart_data_o=0, uart_wr_en_o=0, busy_o=0, frame_done_o=0, seq_o=0, drop_count_o=0, state=IDLE, accumulator=0.
- Reset mid-frame:
  - The next cycle is IDLE with no further writes.
  - The partial frame is abandoned; the downstream parser resyncs on SYNC_BYTE.
  - seq_o and drop_count_o clear.
- Latency: valid_i in cycle 0 gives the SYNC write in cycle 1 if not full.
- Unstalled frame: writes in consecutive cycles 1..N, where N = 2+NBYTES+1 with the checksum or 2+NBYTES without.
- frame_done_o is asserted in cycle N; busy_o falls in cycle N+1.
- Back-to-back reports: a new valid_i is accepted no earlier than cycle N+1. Throughput is one frame per N+1 cycles minimum.
- Each stall cycle delays all following bytes by exactly one cycle.

## Configuration
- REPORT_CHECKSUM_EN defined:
  - The CSUM state and accumulator are compiled in.
  - The frame is SYNC, SEQ, NBYTES data bytes, CSUM.
- REPORT_CHECKSUM_EN undefined:
  - No CSUM state and no accumulator.
  - The frame ends after the last data byte, and frame_done_o/seq increment move to that write.

## Test plan
- Checksum on, DW=16, idle FIFO, data_i=16'h1234 strobe:
  - Writes A5, 00, 12, 34, 26 in cycles 1..5.
  - frame_done_o in cycle 5; seq_o becomes 01.
- Second report 16'hFFFF after the first frame:
  - Writes A5, 01, FF, FF, 01.
  - seq_o becomes 02.
- Report 16'hABCD with uart_fifo_full_i held high for 3 cycles when DATA index 0 is reached:
  - uart_wr_en_o is 0 for exactly those 3 cycles with uart_data_o steady at AB.
  - The frame then completes A5, seq, AB, CD, checksum with no lost byte.
- valid_i pulsed in cycle 2 of a frame, then 300 more strobes during long stalls:
  - Frame contents unchanged.
  - drop_count_o is 1 after the first strobe and saturates at FF.
- rst asserted in cycle 3 of a frame:
  - No writes from the next cycle.
  - busy_o=0, seq_o=0, drop_count_o=0.
  - The next report produces a full frame starting with A5, 00.
- Macro undefined, data_i=16'h1234:
  - Writes A5, 00, 12, 34 only.
  - frame_done_o in cycle 4.
  - 256 frames wrap seq_o from FF to 00.

Source files
------------

// File: rtl/uart_report_framer.sv
// Serialises each accepted power report into a UART byte frame: SYNC, SEQ, data bytes MSB first,
// and a trailing XOR checksum when REPORT_CHECKSUM_EN is defined. Reports arriving mid-frame are dropped and counted.
module uart_report_framer #(
  parameter int          DW        = 16,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] data_i,
  input  logic          valid_i,
  input  logic          uart_fifo_full_i,
  output logic [7:0]    uart_data_o,
  output logic          uart_wr_en_o,
  output logic          busy_o,
  output logic          frame_done_o,
  output logic [7:0]    seq_o,
  output logic [7:0]    drop_count_o
);

  localparam int NBYTES = DW / 8;
  localparam int IW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_SEQ,
`ifdef REPORT_CHECKSUM_EN
    S_DATA,
    S_CSUM
`else
    S_DATA
`endif
  } state_t;

  state_t        r_state;
  logic [DW-1:0] r_shift;
  logic [IW-1:0] r_idx;
  logic [7:0]    r_seq;
  logic [7:0]    r_drop;
`ifdef REPORT_CHECKSUM_EN
  logic [7:0]    r_acc;
`endif

  logic       w_emit;
  logic       w_wr;
  logic       w_last_data;
  logic       w_last;
  logic [7:0] w_byte;

  assign w_emit      = (r_state != S_IDLE);
  assign w_wr        = w_emit && !uart_fifo_full_i;
  assign w_last_data = (r_state == S_DATA) && (r_idx == IW'(NBYTES - 1));
`ifdef REPORT_CHECKSUM_EN
  assign w_last      = (r_state == S_CSUM);
`else
  assign w_last      = w_last_data;
`endif

  // The outgoing byte is a pure function of registered state, so it stays steady through a stall.
  // NOTE: every signal assigned in always_comb gets a default first so no latch can be inferred.
  always_comb begin
    w_byte = 8'h00;
    case (r_state)
      S_SYNC:  w_byte = SYNC_BYTE;
      S_SEQ:   w_byte = r_seq;
      S_DATA:  w_byte = r_shift[DW-1 -: 8];
`ifdef REPORT_CHECKSUM_EN
      S_CSUM:  w_byte = r_acc;
`endif
      default: w_byte = 8'h00;
    endcase
  end

  assign uart_data_o  = w_byte;
  assign uart_wr_en_o = w_wr;
  assign busy_o       = w_emit;
  assign frame_done_o = w_wr && w_last;
  assign seq_o        = r_seq;
  assign drop_count_o = r_drop;

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_shift <= '0;
      r_idx   <= '0;
      r_seq   <= 8'h00;
      r_drop  <= 8'h00;
`ifdef REPORT_CHECKSUM_EN
      r_acc   <= 8'h00;
`endif
    end else begin
      if (valid_i && (r_state != S_IDLE) && (r_drop != 8'hFF))
        r_drop <= r_drop + 8'h01;

      if (w_wr && w_last)
        r_seq <= r_seq + 8'h01;

      case (r_state)
        S_IDLE: begin
          if (valid_i) begin
            r_shift <= data_i;
            r_idx   <= '0;
`ifdef REPORT_CHECKSUM_EN
            r_acc   <= 8'h00;
`endif
            r_state <= S_SYNC;
          end
        end
        S_SYNC: begin
          if (w_wr) r_state <= S_SEQ;
        end
        S_SEQ: begin
          if (w_wr) begin
            r_idx   <= '0;
`ifdef REPORT_CHECKSUM_EN
            r_acc   <= r_acc ^ r_seq;
`endif
            r_state <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_wr) begin
`ifdef REPORT_CHECKSUM_EN
            r_acc   <= r_acc ^ r_shift[DW-1 -: 8];
`endif
            r_shift <= r_shift << 8;
            r_idx   <= r_idx + IW'(1);
            if (w_last_data) begin
`ifdef REPORT_CHECKSUM_EN
              r_state <= S_CSUM;
`else
              r_state <= S_IDLE;
`endif
            end
          end
        end
`ifdef REPORT_CHECKSUM_EN
        S_CSUM: begin
          if (w_wr) r_state <= S_IDLE;
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_report_framer.sv
// Scoreboard bench for uart_report_framer: directed reports push expected bytes; a negedge monitor pops and compares each write.
module tb_uart_report_framer;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] data_i;
  logic        valid_i;
  logic        uart_fifo_full_i;
  logic [7:0]  uart_data_o;
  logic        uart_wr_en_o;
  logic        busy_o;
  logic        frame_done_o;
  logic [7:0]  seq_o;
  logic [7:0]  drop_count_o;

`ifdef REPORT_CHECKSUM_EN
  localparam int N = 5;
`else
  localparam int N = 4;
`endif

  uart_report_framer #(.DW(16), .SYNC_BYTE(8'hA5)) dut (
    .clk              (clk),
    .rst              (rst),
    .data_i           (data_i),
    .valid_i          (valid_i),
    .uart_fifo_full_i (uart_fifo_full_i),
    .uart_data_o      (uart_data_o),
    .uart_wr_en_o     (uart_wr_en_o),
    .busy_o           (busy_o),
    .frame_done_o     (frame_done_o),
    .seq_o            (seq_o),
    .drop_count_o     (drop_count_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [8:0] exp_q[$];   // {last_byte_flag, byte}
  logic [7:0] model_seq = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [7:0] b, input logic last);
    exp_q.push_back({last, b});
  endtask

  // Reference frame builder for reports whose bytes are not hand-listed.
  task automatic push_frame(input logic [15:0] d);
    logic [7:0] acc;
    logic [7:0] b;
    push(8'hA5, 1'b0);
    push(model_seq, 1'b0);
    acc = model_seq;
    for (int i = 0; i < 2; i++) begin
      b = d[15 - 8*i -: 8];
      acc = acc ^ b;
`ifdef REPORT_CHECKSUM_EN
      push(b, 1'b0);
`else
      push(b, i == 1);
`endif
    end
`ifdef REPORT_CHECKSUM_EN
    push(acc, 1'b1);
`endif
    model_seq = model_seq + 8'h01;
  endtask

  // Monitor: every write must match the head of the scoreboard queue.
  always @(negedge clk) begin
    logic [8:0] e;
    if (uart_wr_en_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_write", uart_wr_en_o, 0);
      end else begin
        e = exp_q.pop_front();
        check("write_byte", uart_data_o, e[7:0]);
        check("frame_done_on_write", frame_done_o, e[8]);
      end
    end else if (frame_done_o === 1'b1) begin
      check("frame_done_without_write", frame_done_o, 0);
    end
  end

  // Called at posedge+1 with the DUT idle; returns at posedge+1 in cycle 1 of the frame.
  task automatic send(input logic [15:0] d);
    data_i  = d;
    valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (!busy_o) done = 1;
    end
    if (!done) check("idle_timeout", busy_o, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; data_i = '0; valid_i = 1'b0; uart_fifo_full_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_wr_en", uart_wr_en_o, 0);
    check("reset_busy", busy_o, 0);
    check("reset_data", uart_data_o, 8'h00);
    check("reset_frame_done", frame_done_o, 0);
    check("reset_seq", seq_o, 0);
    check("reset_drop", drop_count_o, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Frame 1: 16'h1234, cycle-accurate timing of strobes.
`ifdef REPORT_CHECKSUM_EN
    push(8'hA5, 0); push(8'h00, 0); push(8'h12, 0); push(8'h34, 0); push(8'h26, 1);
`else
    push(8'hA5, 0); push(8'h00, 0); push(8'h12, 0); push(8'h34, 1);
`endif
    model_seq = 8'h01;
    send(16'h1234);
    for (int k = 1; k <= N + 1; k++) begin
      @(negedge clk);
      check($sformatf("f1_wr_en_c%0d", k), uart_wr_en_o, (k <= N));
      check($sformatf("f1_done_c%0d", k), frame_done_o, (k == N));
      check($sformatf("f1_busy_c%0d", k), busy_o, (k <= N));
    end
    check("f1_seq", seq_o, 8'h01);
    @(posedge clk); #1;

    // Frame 2: 16'hFFFF.
`ifdef REPORT_CHECKSUM_EN
    push(8'hA5, 0); push(8'h01, 0); push(8'hFF, 0); push(8'hFF, 0); push(8'h01, 1);
`else
    push(8'hA5, 0); push(8'h01, 0); push(8'hFF, 0); push(8'hFF, 1);
`endif
    model_seq = 8'h02;
    send(16'hFFFF);
    wait_idle();
    check("f2_seq", seq_o, 8'h02);

    // Frame 3: 16'hABCD with 3 stall cycles at DATA index 0.
`ifdef REPORT_CHECKSUM_EN
    push(8'hA5, 0); push(8'h02, 0); push(8'hAB, 0); push(8'hCD, 0); push(8'h64, 1);
`else
    push(8'hA5, 0); push(8'h02, 0); push(8'hAB, 0); push(8'hCD, 1);
`endif
    model_seq = 8'h03;
    send(16'hABCD);
    @(posedge clk); #1;
    @(posedge clk); #1;
    uart_fifo_full_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_wr_en", uart_wr_en_o, 0);
      check("stall_data", uart_data_o, 8'hAB);
      check("stall_busy", busy_o, 1);
      @(posedge clk); #1;
    end
    uart_fifo_full_i = 1'b0;
    wait_idle();
    check("f3_seq", seq_o, 8'h03);

    // Drops: one strobe mid-frame, then 300 more under a long stall.
    push_frame(16'h5A3C);
    send(16'h5A3C);
    data_i  = 16'hDEAD;
    valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    @(negedge clk);
    check("drop_first", drop_count_o, 8'h01);
    @(posedge clk); #1;
    uart_fifo_full_i = 1'b1;
    valid_i = 1'b1;
    repeat (300) @(posedge clk);
    #1;
    valid_i = 1'b0;
    @(negedge clk);
    check("drop_saturated", drop_count_o, 8'hFF);
    check("drop_stall_wr_en", uart_wr_en_o, 0);
    @(posedge clk); #1;
    uart_fifo_full_i = 1'b0;
    wait_idle();
    check("drop_seq", seq_o, model_seq);

    // Reset in cycle 3: SYNC, SEQ and data byte 0 are written, then nothing.
    push(8'hA5, 0); push(model_seq, 0); push(8'h77, 0);
    send(16'h7788);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_wr_en", uart_wr_en_o, 0);
    check("rst_mid_busy", busy_o, 0);
    check("rst_mid_seq", seq_o, 8'h00);
    check("rst_mid_drop", drop_count_o, 8'h00);
    check("rst_mid_queue_drained", exp_q.size(), 0);
    exp_q.delete();
    model_seq = 8'h00;
    @(posedge clk); #1;
    push_frame(16'h0F0F);
    send(16'h0F0F);
    wait_idle();
    check("post_rst_seq", seq_o, 8'h01);

    // 256 frames: seq_o passes FF -> 00 and returns to its start value.
    for (int i = 0; i < 256; i++) begin
      push_frame(16'(i * 16'h0101 + 16'h0033));
      send(16'(i * 16'h0101 + 16'h0033));
      wait_idle();
      check($sformatf("wrap_seq_%0d", i), seq_o, model_seq);
    end
    check("wrap_seq_final", seq_o, 8'h01);

    check("queue_empty_at_end", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
